uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 52 +++++
 rtl/uart_tx_fifo.sv | 131 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-buffer FSM states and status bit positions.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    POLL,
    WRITE
  } tx_state_t;

  localparam int STAT_FULL    = 15;
  localparam int STAT_OVF     = 13;
  localparam int STAT_TX_BUSY = 15;
  localparam int STAT_RX_FULL = 14;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a pop lets a push land on a full FIFO.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-side transmit FIFO that feeds the UART slave port by polling tx_busy.
// Build with UART_TX_FIFO_OVF_EN for a sticky overflow flag in status bit 13.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [15:0] din,
  output logic [15:0] dout,
  input  logic        a0,
  input  logic        rnw,
  input  logic        cs_b,
  output logic [15:0] u_din,
  input  logic [15:0] u_dout,
  output logic        u_a0,
  output logic        u_rnw,
  output logic        u_cs_b
);

  localparam logic [DEPTH_LOG2:0] ONE = (DEPTH_LOG2+1)'(1);

  tx_state_t           state;
  logic                wr_req;
  logic                pop;
  logic [7:0]          rd_data;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic                ovf;
  logic [15:0]         status;
  logic                unused;

  assign wr_req = !cs_b && !rnw && a0;
  assign pop    = (state == WRITE);
  assign unused = ^{din[15:8], u_dout[14:0]};

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset_b (reset_b),
    .push    (wr_req),
    .pop     (pop),
    .wr_data (din[7:0]),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

`ifdef UART_TX_FIFO_OVF_EN
  logic st_rd;
  logic ovf_q;

  assign st_rd = !cs_b && rnw && !a0;
  assign ovf   = ovf_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ovf_q <= 1'b0;
    end else if (wr_req && full && !pop) begin
      ovf_q <= 1'b1;
    end else if (st_rd) begin
      ovf_q <= 1'b0;
    end
  end
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    status                 = '0;
    status[DEPTH_LOG2:0]   = count;
    status[STAT_FULL]      = full;
    status[STAT_OVF]       = ovf;
  end

  assign dout = a0 ? 16'h0000 : status;

  // Bus outputs are registered with the state so they follow it exactly.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state  <= IDLE;
      u_cs_b <= 1'b1;
      u_rnw  <= 1'b1;
      u_a0   <= 1'b0;
      u_din  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state  <= POLL;
            u_cs_b <= 1'b0;
          end
        end
        POLL: begin
          if (!u_dout[STAT_TX_BUSY]) begin
            state <= WRITE;
            u_rnw <= 1'b0;
            u_a0  <= 1'b1;
            u_din <= {8'h00, rd_data};
          end
        end
        WRITE: begin
          u_rnw <= 1'b1;
          u_a0  <= 1'b0;
          u_din <= '0;
          // A push during WRITE always lands, so it keeps the FIFO non-empty.
          if (count != ONE || wr_req) begin
            state  <= POLL;
            u_cs_b <= 1'b0;
          end else begin
            state  <= IDLE;
            u_cs_b <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          u_cs_b <= 1'b1;
          u_rnw  <= 1'b1;
          u_a0   <= 1'b0;
          u_din  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo with a simple busy-timing UART model.
module tb_uart_tx_fifo;

  logic        clk;
  logic        reset_b;
  logic [15:0] din;
  logic [15:0] dout;
  logic        a0;
  logic        rnw;
  logic        cs_b;
  logic [15:0] u_din;
  logic [15:0] u_dout;
  logic        u_a0;
  logic        u_rnw;
  logic        u_cs_b;

`ifdef UART_TX_FIFO_OVF_EN
  localparam logic [15:0] OVF_BIT = 16'h2000;
`else
  localparam logic [15:0] OVF_BIT = 16'h0000;
`endif
  localparam int BUSY_CYC = 6;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  logic       force_busy = 1'b0;
  int         busy_cnt = 0;
  logic       tx_busy;
  logic [15:0] rd;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk     (clk),
    .reset_b (reset_b),
    .din     (din),
    .dout    (dout),
    .a0      (a0),
    .rnw     (rnw),
    .cs_b    (cs_b),
    .u_din   (u_din),
    .u_dout  (u_dout),
    .u_a0    (u_a0),
    .u_rnw   (u_rnw),
    .u_cs_b  (u_cs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  assign tx_busy = force_busy || (busy_cnt != 0);
  assign u_dout  = {tx_busy, 15'h0000};

  // UART model: loads on a data write, then stays busy for a while.
  always @(posedge clk) begin
    if (reset_b && !u_cs_b && !u_rnw && u_a0) begin
      chk("uart_overrun", {15'h0, tx_busy}, 16'h0000);
      if (exp_q.size() == 0)
        chk("uart_unexpected", u_din, 16'hffff);
      else
        chk("uart_byte", u_din, {8'h00, exp_q.pop_front()});
      busy_cnt <= BUSY_CYC;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic cpu_write(input logic [7:0] v);
    cs_b = 1'b0; rnw = 1'b0; a0 = 1'b1; din = {8'hA5, v};
    @(negedge clk);
    cs_b = 1'b1; rnw = 1'b1; a0 = 1'b0;
  endtask

  task automatic cpu_read_status(output logic [15:0] v);
    cs_b = 1'b0; rnw = 1'b1; a0 = 1'b0;
    #1 v = dout;
    @(negedge clk);
    cs_b = 1'b1;
  endtask

  task automatic wait_write(input string tag);
    int n = 0;
    while (!(u_cs_b == 1'b0 && u_rnw == 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {15'h0, n < 200}, 16'h0001);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 16'(exp_q.size()), 16'h0000);
    repeat (BUSY_CYC + 4) @(negedge clk);
  endtask

  initial begin
    reset_b = 1'b0;
    din = '0; a0 = 1'b0; rnw = 1'b1; cs_b = 1'b1;
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);

    cpu_read_status(rd);
    chk("reset_status", rd, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      chk("reset_idle_cs", {15'h0, u_cs_b}, 16'h0001);
      @(negedge clk);
    end

    // Single byte, UART idle: check POLL/WRITE latency.
    exp_q.push_back(8'h41);
    cpu_write(8'h41);
    chk("lat_n0_bus", {13'h0, u_cs_b, u_rnw, u_a0}, 16'h0006);
    @(negedge clk);
    chk("lat_poll_bus", {13'h0, u_cs_b, u_rnw, u_a0}, 16'h0002);
    @(negedge clk);
    chk("lat_write_bus", {13'h0, u_cs_b, u_rnw, u_a0}, 16'h0001);
    chk("lat_write_din", u_din, 16'h0041);
    @(negedge clk);
    chk("lat_idle_bus", {13'h0, u_cs_b, u_rnw, u_a0}, 16'h0006);
    cpu_read_status(rd);
    chk("lat_status", rd, 16'h0000);
    drain("drain_single");

    // Fill to full with UART busy, overflow, then push during a pop.
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      cpu_write(8'(i));
    end
    cpu_read_status(rd);
    chk("full_status", rd, 16'h8010);
    cpu_write(8'hFF);
    cpu_read_status(rd);
    chk("drop_status", rd, 16'h8010 | OVF_BIT);
    force_busy = 1'b0;
    wait_write("wait_pop_full");
    exp_q.push_back(8'h55);
    cpu_write(8'h55);
    cpu_read_status(rd);
    chk("push_pop_full", rd, 16'h8010);
    drain("drain_full");
    cpu_read_status(rd);
    chk("drained_status", rd, 16'h0000);

    // Reset while a WRITE is on the bus.
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h80 + 8'(i));
      cpu_write(8'h80 + 8'(i));
    end
    cpu_read_status(rd);
    chk("five_status", rd, 16'h0005);
    force_busy = 1'b0;
    wait_write("wait_pop_rst");
    reset_b = 1'b0;
    #1 chk("rst_bus_cs", {15'h0, u_cs_b}, 16'h0001);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    cpu_read_status(rd);
    chk("rst_status", rd, 16'h0000);
    chk("rst_bus_idle", {13'h0, u_cs_b, u_rnw, u_a0}, 16'h0006);

`ifdef UART_TX_FIFO_OVF_EN
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      cpu_write(8'h20 + 8'(i));
    end
    cpu_write(8'hEE);
    cpu_read_status(rd);
    chk("ovf_set", rd, 16'hA010);
    cpu_read_status(rd);
    chk("ovf_clear", rd, 16'h8010);
    force_busy = 1'b0;
    drain("drain_ovf");
`endif

    // Mixed traffic with the UART's own busy timing.
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(8'hC0 + 8'(i));
      cpu_write(8'hC0 + 8'(i));
    end
    drain("drain_mixed");
    cpu_read_status(rd);
    chk("end_status", rd, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
